intipisched: RTL and testbench

Inter-processor-interrupt scheduler. It is a PerInt master that sits in front of the interrupt controller's PerInt slave port and shares that port among REQCOUNT requesters (typically PUs). It arbitrates round-robin and issues the targeted-interrupt command (CMDINTDST) on behalf of the granted requester. If the controller reports an interrupt pending ack, it backs off and retries; the final controller result goes back to the requester.

---
 rtl/intctrl_pkg.sv | 28 ++
 rtl/intipisched_rrarb.sv | 36 +++
 rtl/intipisched.sv | 149 ++++++++++++++
 tb/tb_intipisched.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intctrl_pkg.sv
// Shared interrupt-controller definitions.
// PerInt op codes, controller commands, result codes, scheduler states.
package intctrl_pkg;

   localparam logic [1:0] PINOOP = 2'b00;
   localparam logic [1:0] PIWROP = 2'b01;
   localparam logic [1:0] PIRDOP = 2'b10;
   localparam logic [1:0] PIRWOP = 2'b11;

   localparam logic [1:0] CMDACKINT = 2'b00;
   localparam logic [1:0] CMDINTDST = 2'b01;
   localparam logic [1:0] CMDENAINT = 2'b10;

   // Widest supported data path; users slice [ARCHBITSZ-1:0].
   localparam int RES_MAXW = 64;
   localparam logic [RES_MAXW-1:0] RES_INVALID = '1;
   localparam logic [RES_MAXW-1:0] RES_PENDING =
      {{(RES_MAXW-1){1'b1}}, 1'b0};

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_BACKOFF = 3'd3,
      ST_DONE    = 3'd4
   } isched_state_t;

endpackage

// File: rtl/intipisched_rrarb.sv
// Round-robin find-first-set starting at a pointer.
// Purely combinational; the pointer register lives in the parent.
module intipisched_rrarb #(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          vld,
   output logic [PW-1:0] idx
);

   logic [2*N-1:0] dbl;
   logic [2*N-1:0] rot;

   assign dbl = {req, req};
   assign rot = dbl >> ptr;

   // First set bit of the rotated vector, mapped back to a requester index.
   always_comb begin
      logic [PW:0] s;
      vld = 1'b0;
      idx = '0;
      s   = '0;
      for (int i = 0; i < N; i++) begin
         if (!vld && rot[i]) begin
            vld = 1'b1;
            s   = {1'b0, ptr} + (PW+1)'(i);
            if (s >= (PW+1)'(N))
               s = s - (PW+1)'(N);
            idx = s[PW-1:0];
         end
      end
   end

endmodule

// File: rtl/intipisched.sv
// Inter-processor-interrupt scheduler: shares one PerInt master port
// among requesters, issuing targeted-interrupt commands with retry.
module intipisched
   import intctrl_pkg::*;
#(
   parameter int ARCHBITSZ = 16,
   parameter int REQCOUNT  = 2,
   parameter int RETRYDLY  = 8,
   parameter int MAXRETRY  = 4,
   parameter int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   output logic [1:0]                       m_op_o,
   output logic [ADDRBITSZ-1:0]             m_addr_o,
   output logic [ARCHBITSZ-1:0]             m_data_o,
   input  logic [ARCHBITSZ-1:0]             m_data_i,
   output logic [ARCHBITSZ/8-1:0]           m_sel_o,
   input  logic                             m_rdy_i,
   input  logic [REQCOUNT-1:0]              rqst_i,
   input  logic [REQCOUNT*(ARCHBITSZ-2)-1:0] rqstdst_i,
   output logic [REQCOUNT-1:0]              done_o,
   output logic [ARCHBITSZ-1:0]             result_o,
   output logic                             busy_o
);

   localparam int DSTW = ARCHBITSZ - 2;
   localparam int PW   = (REQCOUNT > 1) ? $clog2(REQCOUNT) : 1;
   localparam int RW   = (MAXRETRY > 0) ? $clog2(MAXRETRY + 1) : 1;
   localparam int BW   = $clog2(RETRYDLY + 1);

   localparam logic [ARCHBITSZ-1:0] RES_PEND =
      RES_PENDING[ARCHBITSZ-1:0];
   localparam logic [RW-1:0]       RETRY_MAX = RW'(MAXRETRY);
   // The WAIT cycle counts as the first backoff cycle.
   localparam logic [BW-1:0]       BK_INIT   = BW'(RETRYDLY - 1);
   localparam logic [PW-1:0]       LAST_IDX  = PW'(REQCOUNT - 1);
   localparam logic [REQCOUNT-1:0] ONE_HOT0  = REQCOUNT'(1);

   isched_state_t   state;
   logic [PW-1:0]   rrptr;
   logic [PW-1:0]   gidx;
   logic [DSTW-1:0] dst;
   logic [RW-1:0]   retry;
   logic [BW-1:0]   bctr;

   logic            arb_vld;
   logic [PW-1:0]   arb_idx;
   logic [DSTW-1:0] gnt_dst;
   logic            pend;

   intipisched_rrarb #(
      .N  (REQCOUNT),
      .PW (PW)
   ) u_arb (
      .req (rqst_i),
      .ptr (rrptr),
      .vld (arb_vld),
      .idx (arb_idx)
   );

   // Destination slice of the requester currently winning arbitration.
   always_comb begin
      gnt_dst = '0;
      for (int k = 0; k < REQCOUNT; k++) begin
         if (arb_idx == PW'(k))
            gnt_dst = rqstdst_i[k*DSTW +: DSTW];
      end
   end

   assign pend     = (m_data_i == RES_PEND) && (retry < RETRY_MAX);
   assign m_addr_o = '0;
   assign busy_o   = (state != ST_IDLE);

   // Scheduler FSM with registered PerInt and completion outputs.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= ST_IDLE;
         rrptr    <= '0;
         gidx     <= '0;
         dst      <= '0;
         retry    <= '0;
         bctr     <= '0;
         m_op_o   <= PINOOP;
         m_data_o <= '0;
         m_sel_o  <= '0;
         done_o   <= '0;
         result_o <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (arb_vld) begin
                  gidx     <= arb_idx;
                  dst      <= gnt_dst;
                  retry    <= '0;
                  m_op_o   <= PIRWOP;
                  m_data_o <= {gnt_dst, CMDINTDST};
                  m_sel_o  <= '1;
                  state    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (m_rdy_i) begin
                  m_op_o   <= PINOOP;
                  m_data_o <= '0;
                  m_sel_o  <= '0;
                  state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (m_rdy_i) begin
                  if (pend) begin
                     retry <= retry + 1'b1;
                     if (BK_INIT == '0) begin
                        m_op_o   <= PIRWOP;
                        m_data_o <= {dst, CMDINTDST};
                        m_sel_o  <= '1;
                        state    <= ST_ISSUE;
                     end else begin
                        bctr  <= BK_INIT;
                        state <= ST_BACKOFF;
                     end
                  end else begin
                     result_o <= m_data_i;
                     done_o   <= ONE_HOT0 << gidx;
                     state    <= ST_DONE;
                  end
               end
            end
            ST_BACKOFF: begin
               bctr <= bctr - 1'b1;
               if (bctr == BW'(1)) begin
                  m_op_o   <= PIRWOP;
                  m_data_o <= {dst, CMDINTDST};
                  m_sel_o  <= '1;
                  state    <= ST_ISSUE;
               end
            end
            ST_DONE: begin
               done_o <= '0;
               rrptr  <= (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_intipisched.sv
// Self-checking bench for intipisched.
// Randomized transactions against a transaction-level reference model.
module tb_intipisched;

   localparam int AW = 16;
   localparam int RC = 2;
   localparam int RD = 8;
   localparam int MR = 4;
   localparam int AD = AW - 1;
   localparam int DW = AW - 2;
   localparam logic [15:0] PEND = 16'hFFFE;
   localparam logic [15:0] INVL = 16'hFFFF;

   logic           clk_i = 1'b0;
   logic           rst_i = 1'b0;
   logic [1:0]     m_op_o;
   logic [AD-1:0]  m_addr_o;
   logic [AW-1:0]  m_data_o;
   logic [AW-1:0]  m_data_i = '0;
   logic [1:0]     m_sel_o;
   logic           m_rdy_i = 1'b1;
   logic [RC-1:0]  rqst_i = '0;
   logic [RC*DW-1:0] rqstdst_i = '0;
   logic [RC-1:0]  done_o;
   logic [AW-1:0]  result_o;
   logic           busy_o;

   intipisched #(
      .ARCHBITSZ (AW),
      .REQCOUNT  (RC),
      .RETRYDLY  (RD),
      .MAXRETRY  (MR)
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .m_op_o    (m_op_o),
      .m_addr_o  (m_addr_o),
      .m_data_o  (m_data_o),
      .m_data_i  (m_data_i),
      .m_sel_o   (m_sel_o),
      .m_rdy_i   (m_rdy_i),
      .rqst_i    (rqst_i),
      .rqstdst_i (rqstdst_i),
      .done_o    (done_o),
      .result_o  (result_o),
      .busy_o    (busy_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   logic [15:0] plan[$];
   logic [15:0] resp_q[$];
   int          acc_cyc[$];
   logic [15:0] acc_dat[$];
   int          op_hi;
   int          done_cyc;
   logic [1:0]  done_val;
   logic [15:0] done_res;
   bit          busy_seen;
   bit          sel_ok;
   int          rr_ptr = 0;

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   // Requester + slave driver for one transaction; records what happened.
   task automatic run_one(input logic [1:0] req, input int stall,
                          input bit keep, input int drop_at);
      acc_cyc.delete();
      acc_dat.delete();
      op_hi = 0;
      done_cyc = -1;
      done_val = '0;
      done_res = '0;
      busy_seen = 0;
      sel_ok = 1;
      rqst_i = req;
      for (int c = 0; c < 200; c++) begin
         m_rdy_i = !(c >= 1 && c <= stall);
         if (c == drop_at) rqst_i = '0;
         if (busy_o) busy_seen = 1;
         if (m_op_o == 2'b11) begin
            op_hi++;
            if (m_sel_o != 2'b11) sel_ok = 0;
            if (m_rdy_i) begin
               acc_cyc.push_back(c);
               acc_dat.push_back(m_data_o);
               if (resp_q.size() > 0) m_data_i = resp_q.pop_front();
               else m_data_i = 16'h0;
            end
         end else if (m_sel_o != 2'b00) begin
            sel_ok = 0;
         end
         if (done_o != '0) begin
            done_cyc = c;
            done_val = done_o;
            done_res = result_o;
            if (!keep) rqst_i = '0;
            tick();
            break;
         end
         tick();
      end
      m_rdy_i = 1'b1;
      resp_q.delete();
      checks++;
      if (done_cyc < 0) begin
         errors++;
         $display("FAIL timeout no done_o within 200 cycles");
      end
   endtask

   // Transaction-level model: attempts, final result, done cycle.
   task automatic model_txn(input int stall, output int n,
                            output logic [15:0] res, output int dc);
      n = 1;
      while (n - 1 < MR && n - 1 < plan.size() && plan[n-1] == PEND)
         n++;
      res = (n - 1 < plan.size()) ? plan[n-1] : 16'h0;
      dc = 1 + stall + (n - 1) * (RD + 1) + 2;
   endtask

   function automatic int pick(input logic [1:0] m, input int p);
      for (int i = 0; i < RC; i++)
         if (m[(p + i) % RC]) return (p + i) % RC;
      return -1;
   endfunction

   task automatic test_reset;
      rst_i = 1'b0;
      tick();
      checks++;
      if ({m_op_o, m_data_o, m_sel_o, done_o, result_o, busy_o}
          !== '0) begin
         errors++;
         $display("FAIL reset_outputs got op=%h d=%h sel=%h dn=%h r=%h b=%b want 0",
                  m_op_o, m_data_o, m_sel_o, done_o, result_o, busy_o);
      end
      checks++;
      if (m_addr_o !== '0) begin
         errors++;
         $display("FAIL reset_addr got %h want 0", m_addr_o);
      end
      rst_i = 1'b1;
      rr_ptr = 0;
      tick();
   endtask

   task automatic test_single;
      logic [15:0] d;
      rqstdst_i = {14'h0, 14'h1};
      plan = {16'h0001};
      resp_q = plan;
      run_one(2'b01, 0, 0, -1);
      d = (acc_dat.size() > 0) ? acc_dat[0] : 16'hxxxx;
      checks++;
      if (d !== 16'h0005) begin
         errors++;
         $display("FAIL single_cmd got %h want 0005", d);
      end
      checks++;
      if (acc_cyc.size() != 1 || acc_cyc[0] != 1) begin
         errors++;
         $display("FAIL single_op_cycle got n=%0d want one op at 1",
                  acc_cyc.size());
      end
      checks++;
      if (done_cyc != 3 || done_val !== 2'b01) begin
         errors++;
         $display("FAIL single_done got c=%0d v=%b want c=3 v=01",
                  done_cyc, done_val);
      end
      checks++;
      if (done_res !== 16'h0001) begin
         errors++;
         $display("FAIL single_result got %h want 0001", done_res);
      end
      checks++;
      if (!busy_seen || !sel_ok) begin
         errors++;
         $display("FAIL single_busy_sel got busy=%b sel=%b want 1 1",
                  busy_seen, sel_ok);
      end
      rr_ptr = 1;
   endtask

   task automatic test_round_robin;
      logic [13:0] dd[2];
      int g;
      rst_i = 1'b0;
      tick();
      rst_i = 1'b1;
      rr_ptr = 0;
      tick();
      dd[0] = 14'h0011;
      dd[1] = 14'h0022;
      rqstdst_i = {dd[1], dd[0]};
      for (int k = 0; k < 3; k++) begin
         g = pick(2'b11, rr_ptr);
         plan = {16'h0040 + 16'(k)};
         resp_q = plan;
         run_one(2'b11, 0, k < 2, -1);
         checks++;
         if (done_val !== 2'(1 << g) || done_res !== 16'h0040 + 16'(k)) begin
            errors++;
            $display("FAIL rr_grant%0d got dn=%b r=%h want dn=%b r=%h",
                     k, done_val, done_res, 2'(1 << g), 16'h0040 + 16'(k));
         end
         checks++;
         if (acc_dat.size() != 1 || acc_dat[0] !== {dd[g], 2'b01}) begin
            errors++;
            $display("FAIL rr_cmd%0d got n=%0d want %h",
                     k, acc_dat.size(), {dd[g], 2'b01});
         end
         rr_ptr = (g + 1) % RC;
      end
   endtask

   task automatic test_retry;
      int n, dc;
      logic [15:0] res;
      rqstdst_i = {14'h0002, 14'h0003};
      plan = {PEND, PEND, 16'h0002};
      model_txn(0, n, res, dc);
      resp_q = plan;
      run_one(2'b10, 0, 0, -1);
      checks++;
      if (acc_cyc.size() != n || op_hi != n) begin
         errors++;
         $display("FAIL retry_ops got acc=%0d hi=%0d want %0d",
                  acc_cyc.size(), op_hi, n);
      end
      checks++;
      if (acc_cyc.size() == 3 &&
          (acc_cyc[1] - acc_cyc[0] != RD + 1 ||
           acc_cyc[2] - acc_cyc[1] != RD + 1)) begin
         errors++;
         $display("FAIL retry_gap got %0d %0d want %0d",
                  acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1], RD + 1);
      end
      checks++;
      if (done_res !== res || done_cyc != dc || done_val !== 2'b10) begin
         errors++;
         $display("FAIL retry_done got r=%h c=%0d v=%b want r=%h c=%0d v=10",
                  done_res, done_cyc, done_val, res, dc);
      end
      rr_ptr = 0;
   endtask

   task automatic test_exhaust;
      int n, dc;
      logic [15:0] res;
      rqstdst_i = {14'h0007, 14'h0009};
      plan = {PEND, PEND, PEND, PEND, PEND, PEND, PEND};
      model_txn(0, n, res, dc);
      resp_q = plan;
      run_one(2'b01, 0, 0, -1);
      checks++;
      if (acc_cyc.size() != 5 || n != 5) begin
         errors++;
         $display("FAIL exhaust_ops got %0d want 5", acc_cyc.size());
      end
      checks++;
      if (done_res !== PEND || done_cyc != dc) begin
         errors++;
         $display("FAIL exhaust_done got r=%h c=%0d want r=%h c=%0d",
                  done_res, done_cyc, PEND, dc);
      end
      rr_ptr = 1;
   endtask

   task automatic test_invalid;
      rqstdst_i = {14'h3FFF, 14'h0004};
      plan = {INVL, 16'h0003};
      resp_q = plan;
      run_one(2'b10, 0, 0, -1);
      checks++;
      if (acc_cyc.size() != 1 || done_res !== INVL) begin
         errors++;
         $display("FAIL invalid got ops=%0d r=%h want ops=1 r=ffff",
                  acc_cyc.size(), done_res);
      end
      rr_ptr = 0;
      tick();
      tick();
      checks++;
      if (result_o !== INVL || done_o !== '0) begin
         errors++;
         $display("FAIL result_hold got r=%h dn=%b want r=ffff dn=00",
                  result_o, done_o);
      end
   endtask

   task automatic test_stall_reset;
      rqstdst_i = {14'h0001, 14'h0006};
      plan = {16'h0007};
      resp_q = plan;
      run_one(2'b01, 3, 0, -1);
      checks++;
      if (op_hi != 4 || acc_cyc.size() != 1 || acc_cyc[0] != 4) begin
         errors++;
         $display("FAIL stall_hold got hi=%0d acc=%0d want hi=4 at 4",
                  op_hi, acc_cyc.size());
      end
      checks++;
      if (done_cyc != 6 || done_res !== 16'h0007 || !sel_ok) begin
         errors++;
         $display("FAIL stall_done got c=%0d r=%h sel=%b want c=6 r=0007",
                  done_cyc, done_res, sel_ok);
      end
      rr_ptr = 1;
      rqst_i = 2'b10;
      tick();
      tick();
      checks++;
      if (busy_o !== 1'b1 || m_op_o !== 2'b00) begin
         errors++;
         $display("FAIL wait_state got b=%b op=%h want b=1 op=0",
                  busy_o, m_op_o);
      end
      rst_i = 1'b0;
      #1;
      checks++;
      if ({m_op_o, m_data_o, m_sel_o, done_o, result_o, busy_o}
          !== '0) begin
         errors++;
         $display("FAIL reset_wait got op=%h d=%h sel=%h dn=%h r=%h b=%b want 0",
                  m_op_o, m_data_o, m_sel_o, done_o, result_o, busy_o);
      end
      tick();
      rqst_i = '0;
      rst_i = 1'b1;
      rr_ptr = 0;
      tick();
   endtask

   task automatic test_random;
      for (int it = 0; it < 12; it++) begin
         logic [1:0]  mask;
         logic [13:0] d0, d1, dg;
         logic [15:0] res, fin;
         int npend, stall, g, n, dc;
         mask = 2'($urandom_range(1, 3));
         d0 = 14'($urandom);
         d1 = 14'($urandom);
         rqstdst_i = {d1, d0};
         npend = $urandom_range(0, 6);
         plan.delete();
         for (int i = 0; i < npend; i++) plan.push_back(PEND);
         fin = ($urandom_range(0, 3) == 0) ? INVL
                                           : 16'($urandom_range(0, 200));
         plan.push_back(fin);
         plan.push_back(16'h0033);
         stall = $urandom_range(0, 2);
         g = pick(mask, rr_ptr);
         dg = (g == 0) ? d0 : d1;
         model_txn(stall, n, res, dc);
         resp_q = plan;
         run_one(mask, stall, 0, (it % 3 == 0) ? 2 : -1);
         checks++;
         if (done_val !== 2'(1 << g) || done_res !== res) begin
            errors++;
            $display("FAIL rand%0d_done got dn=%b r=%h want dn=%b r=%h",
                     it, done_val, done_res, 2'(1 << g), res);
         end
         checks++;
         if (acc_cyc.size() != n || done_cyc != dc ||
             op_hi != n + stall) begin
            errors++;
            $display("FAIL rand%0d_timing got ops=%0d c=%0d hi=%0d want ops=%0d c=%0d hi=%0d",
                     it, acc_cyc.size(), done_cyc, op_hi, n, dc, n + stall);
         end
         checks++;
         if (acc_dat.size() == 0 || acc_dat[0] !== {dg, 2'b01} || !sel_ok) begin
            errors++;
            $display("FAIL rand%0d_cmd got n=%0d sel=%b want %h",
                     it, acc_dat.size(), sel_ok, {dg, 2'b01});
         end
         rr_ptr = (g + 1) % RC;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_retry();
      test_exhaust();
      test_invalid();
      test_stall_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
